// File: rtl/mem_stage_pipe.sv
// MEM pipeline stage: passes ALU results to WB and runs one data-memory
// transaction per load/store, stalling upstream until ack or timeout.
module mem_stage_pipe #(
  parameter int REG_AW  = 5,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [REG_AW-1:0] dest_addr,
  input  logic              write_or_not,
  input  logic [31:0]       wdata,
  input  logic [31:0]       store_data,
  input  logic [2:0]        mem_op,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [3:0]        dm_be,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata,
  input  logic              dm_ack,
  output logic              stall_req,
  output logic [REG_AW-1:0] dest_addr_output,
  output logic              write_or_not_output,
  output logic [31:0]       wdata_output,
  output logic              align_err,
  output logic              bus_err,
  output logic              fsm_state
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [2:0] OP_NONE = 3'd0, OP_LB = 3'd1, OP_LBU = 3'd2, OP_LH = 3'd3,
                         OP_LHU = 3'd4, OP_LW = 3'd5, OP_SB = 3'd6, OP_SW = 3'd7;
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       sdata_q, sdata_d;
  logic [REG_AW-1:0] dest_q, dest_d;
  logic              we_q, we_d;
  logic [REG_AW-1:0] dest_out_q, dest_out_d;
  logic              we_out_q, we_out_d;
  logic [31:0]       wd_out_q, wd_out_d;
  logic              align_q, align_d;
  logic              bus_q, bus_d;

  logic        in_aligned, accept, busy;
  logic [31:0] byte_lane, half_lane, load_data;
  logic [ADDR_W-1:0] busy_addr;

  assign busy      = (state_q == BUSY);
  assign busy_addr = addr_q[ADDR_W-1:0];
  assign fsm_state = state_q;

  always_comb begin
    in_aligned = 1'b1;
    case (mem_op)
      OP_LH, OP_LHU: in_aligned = (wdata[0] == 1'b0);
      OP_LW, OP_SW:  in_aligned = (wdata[1:0] == 2'b00);
      default:       in_aligned = 1'b1;
    endcase
  end

  assign accept = in_valid && (mem_op != OP_NONE) && in_aligned;

  // rst gates the IDLE term so the stall drops before the next edge.
  assign stall_req = !rst && ((!busy && accept) || (busy && !dm_ack));

  assign dm_req   = busy;
  assign dm_we    = busy && (op_q == OP_SB || op_q == OP_SW);
  assign dm_addr  = {busy_addr[ADDR_W-1:2], 2'b00};
  assign dm_wdata = (op_q == OP_SB) ? {4{sdata_q[7:0]}} : sdata_q;

  always_comb begin
    dm_be = 4'b0000;
    if (busy) begin
      case (op_q)
        OP_LW, OP_SW:  dm_be = 4'b1111;
        OP_LH, OP_LHU: dm_be = 4'b0011 << {addr_q[1], 1'b0};
        default:       dm_be = 4'b0001 << addr_q[1:0];
      endcase
    end
  end

  always_comb begin
    byte_lane = dm_rdata >> {addr_q[1:0], 3'b000};
    half_lane = dm_rdata >> {addr_q[1], 4'b0000};
    case (op_q)
      OP_LB:   load_data = {{24{byte_lane[7]}}, byte_lane[7:0]};
      OP_LBU:  load_data = {24'h0, byte_lane[7:0]};
      OP_LH:   load_data = {{16{half_lane[15]}}, half_lane[15:0]};
      OP_LHU:  load_data = {16'h0, half_lane[15:0]};
      OP_LW:   load_data = dm_rdata;
      default: load_data = addr_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    addr_d     = addr_q;
    sdata_d    = sdata_q;
    dest_d     = dest_q;
    we_d       = we_q;
    dest_out_d = dest_out_q;
    we_out_d   = 1'b0;
    wd_out_d   = wd_out_q;
    align_d    = 1'b0;
    bus_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (mem_op == OP_NONE) begin
            dest_out_d = dest_addr;
            we_out_d   = write_or_not;
            wd_out_d   = wdata;
          end else if (in_aligned) begin
            state_d = BUSY;
            cnt_d   = '0;
            op_d    = mem_op;
            addr_d  = wdata;
            sdata_d = store_data;
            dest_d  = dest_addr;
            we_d    = write_or_not;
          end else begin
            dest_out_d = dest_addr;
            wd_out_d   = wdata;
            align_d    = 1'b1;
          end
        end
      end
      BUSY: begin
        // Ack is tested first so an ack on the last allowed cycle completes.
        if (dm_ack) begin
          state_d    = IDLE;
          dest_out_d = dest_q;
          we_out_d   = we_q;
          wd_out_d   = load_data;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = IDLE;
          bus_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= OP_NONE;
      addr_q     <= '0;
      sdata_q    <= '0;
      dest_q     <= '0;
      we_q       <= 1'b0;
      dest_out_q <= '0;
      we_out_q   <= 1'b0;
      wd_out_q   <= '0;
      align_q    <= 1'b0;
      bus_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      sdata_q    <= sdata_d;
      dest_q     <= dest_d;
      we_q       <= we_d;
      dest_out_q <= dest_out_d;
      we_out_q   <= we_out_d;
      wd_out_q   <= wd_out_d;
      align_q    <= align_d;
      bus_q      <= bus_d;
    end
  end

  assign dest_addr_output    = dest_out_q;
  assign write_or_not_output = we_out_q;
  assign wdata_output        = wd_out_q;
  assign align_err           = align_q;
  assign bus_err             = bus_q;

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Directed bench for mem_stage_pipe: pass-through, loads/stores, misalignment,
// timeout and asynchronous reset, with hand-computed expected values.
module tb_mem_stage_pipe;

  logic        clk, rst;
  logic        in_valid, write_or_not, dm_ack;
  logic [4:0]  dest_addr;
  logic [31:0] wdata, store_data, dm_rdata;
  logic [2:0]  mem_op;
  logic        dm_req, dm_we, stall_req, write_or_not_output, align_err, bus_err, fsm_state;
  logic [31:0] dm_addr, dm_wdata, wdata_output;
  logic [3:0]  dm_be;
  logic [4:0]  dest_addr_output;

  int n_vec = 0;
  int n_err = 0;
  int stall_cycles = 0;
  int s0;

  mem_stage_pipe #(.REG_AW(5), .ADDR_W(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .dest_addr(dest_addr),
    .write_or_not(write_or_not), .wdata(wdata), .store_data(store_data),
    .mem_op(mem_op), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .stall_req(stall_req), .dest_addr_output(dest_addr_output),
    .write_or_not_output(write_or_not_output), .wdata_output(wdata_output),
    .align_err(align_err), .bus_err(bus_err), .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (!rst && stall_req === 1'b1) stall_cycles++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [4:0] d,
                       input logic we, input logic [31:0] a, input logic [31:0] sd);
    in_valid = v; mem_op = op; dest_addr = d; write_or_not = we;
    wdata = a; store_data = sd;
  endtask

  // Issue one memory op, ack it on BUSY cycle ack_cyc, check bus and WB result.
  task automatic run_mem(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] sd, input logic [31:0] rd, input int ack_cyc,
                         input logic [3:0] exp_be, input logic [31:0] exp_bus_wd,
                         input logic [31:0] exp_out);
    logic is_store;
    is_store = (op == 3'd6 || op == 3'd7);
    drive(1'b1, op, 5'd9, !is_store, a, sd);
    @(negedge clk);
    check({tag, " accept stall"}, stall_req, 1);
    check({tag, " accept no req"}, dm_req, 0);
    step();
    for (int c = 1; c <= ack_cyc; c++) begin
      if (c == ack_cyc) begin dm_ack = 1'b1; dm_rdata = rd; end
      @(negedge clk);
      check({tag, " dm_req"}, dm_req, 1);
      check({tag, " stall"}, stall_req, (c != ack_cyc));
      check({tag, " wb gated"}, write_or_not_output, 0);
      if (c == 1) begin
        check({tag, " dm_be"}, dm_be, exp_be);
        check({tag, " dm_addr"}, dm_addr, {a[31:2], 2'b00});
        check({tag, " dm_we"}, dm_we, is_store);
        if (is_store) check({tag, " dm_wdata"}, dm_wdata, exp_bus_wd);
      end
      step();
    end
    dm_ack = 1'b0;
    in_valid = 1'b0;
    check({tag, " wdata_out"}, wdata_output, exp_out);
    check({tag, " we_out"}, write_or_not_output, !is_store);
    check({tag, " dest_out"}, dest_addr_output, 9);
    check({tag, " idle"}, fsm_state, 0);
    check({tag, " no bus_err"}, bus_err, 0);
  endtask

  initial begin
    rst = 1'b1; dm_ack = 1'b0; dm_rdata = '0;
    drive(1'b0, 3'd0, 5'd0, 1'b0, 32'h0, 32'h0);
    #12;
    check("rst dest", dest_addr_output, 0);
    check("rst we", write_or_not_output, 0);
    check("rst wdata", wdata_output, 0);
    check("rst errs", {align_err, bus_err}, 0);
    check("rst req/stall", {dm_req, dm_we, stall_req}, 0);
    check("rst be", dm_be, 0);
    check("rst state", fsm_state, 0);
    @(negedge clk); rst = 1'b0;
    step();

    // pass-through
    s0 = stall_cycles;
    drive(1'b1, 3'd0, 5'd3, 1'b1, 32'h1234, 32'h0);
    @(negedge clk);
    check("pass stall", stall_req, 0);
    step();
    check("pass dest", dest_addr_output, 3);
    check("pass we", write_or_not_output, 1);
    check("pass wdata", wdata_output, 32'h1234);
    in_valid = 1'b0;
    step();
    check("bubble we", write_or_not_output, 0);
    check("pass stall count", stall_cycles - s0, 0);

    // LB sign-extended, ack on third BUSY cycle -> three stall cycles
    s0 = stall_cycles;
    run_mem("lb", 3'd1, 32'h102, 32'h0, 32'h0080_0000, 3, 4'b0100, 32'h0, 32'hFFFF_FF80);
    check("lb stall count", stall_cycles - s0, 3);

    run_mem("sb", 3'd6, 32'h203, 32'hAB, 32'h0, 1, 4'b1000, 32'hABAB_ABAB, 32'h203);
    run_mem("sw", 3'd7, 32'h310, 32'hCAFE_0001, 32'h0, 2, 4'b1111, 32'hCAFE_0001, 32'h310);
    run_mem("lh", 3'd3, 32'h102, 32'h0, 32'h8001_0000, 1, 4'b1100, 32'h0, 32'hFFFF_8001);
    run_mem("lhu", 3'd4, 32'h100, 32'h0, 32'h1234_F00D, 1, 4'b0011, 32'h0, 32'h0000_F00D);
    run_mem("lbu", 3'd2, 32'h101, 32'h0, 32'h0000_9A00, 1, 4'b0010, 32'h0, 32'h0000_009A);
    run_mem("lw", 3'd5, 32'h300, 32'h0, 32'hDEAD_BEEF, 1, 4'b1111, 32'h0, 32'hDEAD_BEEF);

    // misaligned LW and LH
    drive(1'b1, 3'd5, 5'd7, 1'b1, 32'h6, 32'h0);
    @(negedge clk);
    check("mis lw stall", stall_req, 0);
    check("mis lw req", dm_req, 0);
    step();
    in_valid = 1'b0;
    check("mis lw align_err", align_err, 1);
    check("mis lw we", write_or_not_output, 0);
    check("mis lw dest", dest_addr_output, 7);
    check("mis lw state", fsm_state, 0);
    step();
    check("mis lw pulse once", align_err, 0);
    drive(1'b1, 3'd3, 5'd4, 1'b1, 32'h101, 32'h0);
    step();
    in_valid = 1'b0;
    check("mis lh align_err", align_err, 1);
    check("mis lh dest", dest_addr_output, 4);

    // ack while idle is ignored
    dm_ack = 1'b1;
    step();
    dm_ack = 1'b0;
    check("idle ack state", fsm_state, 0);
    check("idle ack we", write_or_not_output, 0);

    // timeout: no ack for 15 BUSY cycles
    drive(1'b1, 3'd5, 5'd2, 1'b1, 32'h40, 32'h0);
    step();
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      check("to busy req", dm_req, 1);
      check("to no early bus_err", bus_err, 0);
      step();
    end
    in_valid = 1'b0;
    check("to bus_err", bus_err, 1);
    check("to idle", fsm_state, 0);
    check("to req drop", dm_req, 0);
    check("to we", write_or_not_output, 0);
    step();
    check("to bus_err pulse", bus_err, 0);

    // ack on the 15th BUSY cycle wins over timeout
    run_mem("ack15", 3'd5, 32'h44, 32'h0, 32'h0BAD_F00D, 15, 4'b1111, 32'h0, 32'h0BAD_F00D);
    step();
    check("ack15 no late bus_err", bus_err, 0);

    // asynchronous reset in the middle of BUSY
    drive(1'b1, 3'd5, 5'd6, 1'b1, 32'h80, 32'h0);
    step();
    @(negedge clk);
    check("mid busy req", dm_req, 1);
    #2 rst = 1'b1;
    #1;
    check("arst req", dm_req, 0);
    check("arst stall", stall_req, 0);
    check("arst we/be", {dm_we, dm_be}, 0);
    check("arst outs", {dest_addr_output, write_or_not_output, wdata_output}, 0);
    check("arst errs", {align_err, bus_err}, 0);
    check("arst state", fsm_state, 0);
    in_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    step();
    check("post rst idle", fsm_state, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_stage_pipe.md
MEM_STAGE_PIPE -- requirements
Module: mem_stage_pipe

Interface
REQ-001 The block SHALL have parameter REG_AW, default 5, giving the register-file address width.
REQ-002 The block SHALL have parameter ADDR_W, default 32, giving the data-memory byte-address width.
REQ-003 The block SHALL have parameter TIMEOUT, default 15, giving the maximum BUSY cycles waited for dm_ack.
REQ-004 Port clk: input, 1 bit, the single clock; all state SHALL change on its rising edge.
REQ-005 Port rst: input, 1 bit, asynchronous, active-high reset.
REQ-006 Port in_valid: input, 1 bit, an instruction from EX is present.
REQ-007 Port dest_addr: input, REG_AW bits, writeback register index.
REQ-008 Port write_or_not: input, 1 bit, register writeback enable.
REQ-009 Port wdata: input, 32 bits, ALU result; this is the memory byte address for memory ops (low ADDR_W bits used).
REQ-010 Port store_data: input, 32 bits, rt value for stores.
REQ-011 Port mem_op: input, 3 bits, with encoding 0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SW.
REQ-012 Ports dm_req/dm_we/dm_addr/dm_be/dm_wdata: outputs of 1/1/ADDR_W/4/32 bits, the data-memory request.
REQ-013 Ports dm_rdata/dm_ack: inputs of 32/1 bits, the data-memory response.
REQ-014 Port stall_req: output, 1 bit, requests that upstream stages hold.
REQ-015 Ports dest_addr_output/write_or_not_output/wdata_output: registered outputs of REG_AW/1/32 bits, sent to WB.
REQ-016 Ports align_err/bus_err: outputs, 1 bit each, one-cycle registered error pulses.

Function
REQ-017 The FSM SHALL have states IDLE and BUSY, and SHALL reset to IDLE.
REQ-018 Alignment SHALL be: LH/LHU aligned iff addr[0]==0; LW/SW aligned iff addr[1:0]==0; byte ops always aligned.
REQ-019 In IDLE with in_valid=1 and mem_op=NONE, the inputs SHALL be registered to the outputs on the next edge (latency 1), with no stall.
REQ-020 In IDLE with in_valid=0, write_or_not_output SHALL be 0 on the next edge (bubble).
REQ-021 In IDLE with in_valid=1, an aligned memory op, and no reset, the FSM SHALL go to BUSY and stall_req SHALL assert combinationally in the same cycle.
REQ-022 In BUSY, dm_req SHALL be 1, dm_we SHALL be 1 for SB/SW, and dm_addr SHALL be the word-aligned address ({addr[ADDR_W-1:2],2'b00}).
REQ-023 dm_be SHALL be 4'b1111 for word ops, 4'b0011<<addr[1] *2 for halfwords, and 4'b0001<<addr[1:0] for bytes; for SB, dm_wdata SHALL be store_data[7:0] replicated four times.
REQ-024 stall_req SHALL equal (IDLE & accepted mem op) | (BUSY & ~dm_ack).
REQ-025 Upstream SHALL hold all inputs stable while stall_req=1; the block SHALL NOT re-sample them in BUSY.
REQ-026 While stall_req=1, write_or_not_output SHALL be 0.
REQ-027 On dm_ack in BUSY, the FSM SHALL return to IDLE and register dest_addr and write_or_not; wdata_output SHALL be the extracted load data for loads and wdata for stores.
REQ-028 Load extraction SHALL select the byte/half lane by addr[1:0]/addr[1]; LB/LH SHALL sign-extend and LBU/LHU SHALL zero-extend to 32 bits.
REQ-029 A timeout counter SHALL clear on entry to BUSY and increment each BUSY cycle without ack.
REQ-030 If the counter reaches TIMEOUT without ack, the FSM SHALL go to IDLE, drop dm_req, pulse bus_err for 1 cycle, and set write_or_not_output=0.
REQ-031 If dm_ack arrives in the same cycle as the count reaches TIMEOUT, the ack SHALL win.
REQ-032 A misaligned op SHALL issue no request and no stall, SHALL pulse align_err on the next edge, and SHALL set write_or_not_output=0 with dest_addr_output still registered.
REQ-033 dm_ack while in IDLE SHALL be ignored.

Reset
REQ-034 When rst=1, the block SHALL asynchronously force IDLE, counter=0, dest_addr_output=0, write_or_not_output=0, wdata_output=0, and align_err=bus_err=0.
REQ-035 During rst, dm_req, dm_we, dm_be, and stall_req SHALL be 0 immediately, including mid-BUSY; the transaction SHALL be abandoned.

Verification
REQ-036 Pass-through: in_valid=1, mem_op=0, dest=3, we=1, wdata=0x1234 -> next edge outputs 3/1/0x1234, stall_req never asserts.
REQ-037 LB sign: addr 0x102, dm_rdata 0x00800000, ack after 2 BUSY cycles -> wdata_output 0xFFFFFF80, stall_req high for exactly 3 cycles.
REQ-038 SB: addr 0x203, store_data 0xAB -> dm_be 4'b1000, dm_wdata 0xABABABAB, dm_we=1, dm_addr 0x200.
REQ-039 Misaligned LW: addr 0x6 -> no dm_req, align_err pulses once, write_or_not_output=0.
REQ-040 Timeout: LW with no ack -> bus_err pulses after 15 BUSY cycles, then FSM in IDLE; a further variant with ack on cycle 15 -> normal completion, no bus_err.
REQ-041 Reset mid-BUSY: assert rst asynchronously between edges -> dm_req and stall_req drop before the next edge, and all outputs are 0.
